idli_retire_trace_m: RTL and testbench
======================================

// Module: idli_retire_trace_m
// PURPOSE
// Synthesisable retirement trace buffer, driven by EX-stage strobes.
// Builds one record per retired instruction: PC, mask of GPRs written, and predicate write/value.
// Queues records in a DEPTH-entry FIFO drained over a valid/ready port.
// Generalises the bench-only scoreboard: parametrised width/depth/regs, multi-record buffering,
// selectable overflow policy, sticky overflow. Sits beside ex_u; consumed by TB or debug UART.
// PARAMETERS
// DATA_W    16  width of PC field
// NUM_REGS  16  GPR count; r0 never recorded
// DEPTH      8  FIFO entries, power of two, >=2
// CTR_W      2  width of sync counter (2**CTR_W GCK per slice period)
// WRAP       0  0: drop new record when full; 1: overwrite oldest when full
// PORTS
// gck            in   1                    core clock, all state on posedge
// rst_n          in   1                    async active-low reset
// i_ctr          in   CTR_W                sync counter (ctr_q)
// i_run_instr    in   1                    instruction executing this period
// i_skip_instr   in   1                    instruction predicated off
// i_enc_new      in   1                    new encoding valid in EX (enc_vld_q && enc_new_q)
// i_pc           in   DATA_W               PC of instruction in EX
// i_dst_reg_wr   in   1                    GPR write this instruction
// i_dst_reg      in   $clog2(NUM_REGS)     GPR index written
// i_dst_pred     in   1                    destination is P
// i_pred         in   1                    current predicate register value
// i_rec_rdy      in   1                    consumer accepts head record
// i_ovf_clr      in   1                    clear sticky overflow
// o_rec_vld      out  1                    head record valid
// o_rec_pc       out  DATA_W               head record PC
// o_rec_regs     out  NUM_REGS             head record GPR write mask (bit0 always 0)
// o_rec_pwr      out  1                    head record wrote predicate
// o_rec_pval     out  1                    predicate value after retirement
// o_count        out  $clog2(DEPTH+1)      occupied entries
// o_ovf          out  1                    sticky: a record was dropped or overwritten
// BEHAVIOUR
// - Reset (async, rst_n low): FIFO empty, pointers 0, storage 0.
//   Reset values: o_rec_vld=0, o_count=0, o_ovf=0, all record outputs 0; pending record cleared.
// - Pending record is updated only when i_ctr==0:
//   - i_enc_new: pend_pc<=i_pc.
//   - i_dst_reg_wr && i_dst_reg!=0: pend_regs[i_dst_reg]<=1.
//   - i_run_instr && i_dst_pred: pend_pwr<=!i_skip_instr.
// - done_d = (i_ctr=='1) && i_run_instr; done_q = done_d flopped.
// - In the done_q cycle: push {pend_pc, pend_regs, pend_pwr, i_pred}, then clear pend_regs/pend_pwr.
// - done_q always falls on i_ctr==0. When a clear and a set hit the same cycle, the set wins:
//   next pend_regs = new bit only; pend_pwr = new value.
// - FIFO is first-word-fall-through: o_rec_* reflect the head entry whenever o_rec_vld=1.
// - Pop = o_rec_vld && i_rec_rdy. Push and pop in the same cycle are both honoured;
//   count is unchanged, including when full.
// - Full && push && !pop:
//   - WRAP=0: record discarded, o_ovf<=1.
//   - WRAP=1: oldest entry discarded (rd_ptr++), new record written, o_ovf<=1, count stays DEPTH.
// - Empty && pop: impossible, since o_rec_vld=0.
// - o_rec_* hold stable while o_rec_vld && !i_rec_rdy, except under WRAP=1 overwrite.
// - o_ovf: set has priority over i_ovf_clr in the same cycle.
// - Pointers are $clog2(DEPTH) bits and wrap naturally; count is a separate register.
// - Latency: record visible on o_rec_vld 1 GCK after done_q (push registered).
// TESTING
// - Reset: rst_n low mid-push -> o_rec_vld=0, o_count=0, o_ovf=0 on the same edge.
// - Single retire: PC=0x0042 writing r3, i_rdy=1 -> one record {pc=0x0042, regs=0x0008, pwr=0}.
// - r0 write plus pred write with skip=0, i_pred=1 -> regs=0x0000, pwr=1, pval=1.
// - Skipped pred instr -> pwr=0.
// - Back-to-back retires: r1 then r2 in consecutive periods -> two records, masks 0x0002 and 0x0004.
//   No mask leak between records.
// - Overflow, WRAP=0, DEPTH=8, i_rec_rdy=0, 9 retires (PCs 0..8) -> count=8, o_ovf=1, head pc=0.
//   Drain yields PCs 0..7.
// - Same stimulus with WRAP=1 -> count=8, o_ovf=1, drain yields PCs 1..8.
//   Then i_ovf_clr -> o_ovf=0.
// - Full FIFO with push and pop in the same cycle -> count stays 8, o_ovf stays 0, order preserved.

Source files
------------

// File: rtl/idli_retire_trace_m.sv
// Retirement trace buffer: one record per retired instruction (PC, GPR write mask, predicate write/value).
// Latency: a record becomes visible 1 gck after done_q, because the push into the FIFO is registered.
// Backpressure: FWFT FIFO; when full, a new record is dropped (WRAP=0) or replaces the oldest (WRAP=1), and either case sets o_ovf.
module idli_retire_trace_m #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int DEPTH    = 8,
  parameter int CTR_W    = 2,
  parameter int WRAP     = 0
) (
  input  logic                         gck,
  input  logic                         rst_n,
  input  logic [CTR_W-1:0]             i_ctr,
  input  logic                         i_run_instr,
  input  logic                         i_skip_instr,
  input  logic                         i_enc_new,
  input  logic [DATA_W-1:0]            i_pc,
  input  logic                         i_dst_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0]  i_dst_reg,
  input  logic                         i_dst_pred,
  input  logic                         i_pred,
  input  logic                         i_rec_rdy,
  input  logic                         i_ovf_clr,
  output logic                         o_rec_vld,
  output logic [DATA_W-1:0]            o_rec_pc,
  output logic [NUM_REGS-1:0]          o_rec_regs,
  output logic                         o_rec_pwr,
  output logic                         o_rec_pval,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit WRAP_EN = (WRAP != 0);

  typedef struct packed {
    logic [DATA_W-1:0]   pc;
    logic [NUM_REGS-1:0] regs;
    logic                pwr;
    logic                pval;
  } rec_t;

  // Record under construction for the instruction currently in EX
  logic [DATA_W-1:0]   pend_pc;
  logic [NUM_REGS-1:0] pend_regs;
  logic                pend_pwr;
  logic                done_q;

  logic                slot0;
  logic                done_d;
  logic                reg_set;
  logic                pwr_set;
  logic [NUM_REGS-1:0] regs_nxt;
  logic                pwr_nxt;

  // FIFO state
  rec_t                mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                ovf;

  logic                push;
  logic                pop;
  logic                full;
  logic                wr_en;
  logic                rd_adv;
  logic                ovf_set;
  rec_t                new_rec;
  rec_t                head;

  assign slot0   = (i_ctr == '0);
  assign done_d  = (i_ctr == '1) && i_run_instr;
  assign reg_set = slot0 && i_dst_reg_wr && (i_dst_reg != '0);
  assign pwr_set = slot0 && i_run_instr && i_dst_pred;

  // Next pending mask/predicate: retirement clears, a same-cycle set from the next instruction wins
  always_comb begin
    regs_nxt = done_q ? '0 : pend_regs;
    if (reg_set) begin
      regs_nxt[i_dst_reg] = 1'b1;
    end
    pwr_nxt = done_q ? 1'b0 : pend_pwr;
    if (pwr_set) begin
      pwr_nxt = !i_skip_instr;
    end
  end

  // Pending record and the retirement strobe, flopped one cycle after the last slice
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc   <= '0;
      pend_regs <= '0;
      pend_pwr  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (slot0 && i_enc_new) begin
        pend_pc <= i_pc;
      end
      pend_regs <= regs_nxt;
      pend_pwr  <= pwr_nxt;
      done_q    <= done_d;
    end
  end

  assign new_rec = '{pc: pend_pc, regs: pend_regs, pwr: pend_pwr, pval: i_pred};

  assign push    = done_q;
  assign pop     = (count != '0) && i_rec_rdy;
  assign full    = (count == FULL_CNT);
  // A full FIFO still accepts a write when the head leaves this cycle or when overwriting is enabled
  assign wr_en   = push && (!full || pop || WRAP_EN);
  assign rd_adv  = pop || (push && full && WRAP_EN);
  assign ovf_set = push && full && !pop;

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= new_rec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_adv) begin
        count <= count + 1'b1;
      end else if (rd_adv && !wr_en) begin
        count <= count - 1'b1;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign o_rec_vld  = (count != '0);
  assign o_rec_pc   = head.pc;
  assign o_rec_regs = head.regs;
  assign o_rec_pwr  = head.pwr;
  assign o_rec_pval = head.pval;
  assign o_count    = count;
  assign o_ovf      = ovf;

endmodule

// File: tb/tb_idli_retire_trace_m.sv
// Bench for idli_retire_trace_m: a drop-policy and an overwrite-policy instance share one stimulus stream.
// Latency: scoreboard queues model FIFO contents cycle by cycle, checked mid-cycle.
// Backpressure: consumer ready is driven per phase (low, high, random, push-cycle only).
module tb_idli_retire_trace_m;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] regs;
    logic        pwr;
    logic        pval;
  } rec_t;

  logic        gck = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_ctr = '0;
  logic        i_run_instr = 1'b0;
  logic        i_skip_instr = 1'b0;
  logic        i_enc_new = 1'b0;
  logic [15:0] i_pc = '0;
  logic        i_dst_reg_wr = 1'b0;
  logic [3:0]  i_dst_reg = '0;
  logic        i_dst_pred = 1'b0;
  logic        i_pred = 1'b0;
  logic        i_rec_rdy = 1'b0;
  logic        i_ovf_clr = 1'b0;

  logic        vld0, pwr0, pval0, ovf0;
  logic [15:0] pc0, regs0;
  logic [3:0]  cnt0;
  logic        vld1, pwr1, pval1, ovf1;
  logic [15:0] pc1, regs1;
  logic [3:0]  cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: expected FIFO contents and sticky flag per instance
  rec_t q0[$];
  rec_t q1[$];
  bit   mov0 = 1'b0;
  bit   mov1 = 1'b0;
  bit   pf, pb, os;

  // Stimulus-side knowledge of which record retires in the current cycle
  bit          exp_push = 1'b0;
  rec_t        exp_rec = '0;
  bit          pend_done = 1'b0;
  rec_t        pend_rec = '0;
  logic [15:0] model_pc = '0;
  int          rdy_mode = 0;
  bit          clr_once = 1'b0;
  bit          clr_rand = 1'b0;

  idli_retire_trace_m #(.WRAP(0)) u_dut0 (
    .gck(gck), .rst_n(rst_n), .i_ctr(i_ctr), .i_run_instr(i_run_instr),
    .i_skip_instr(i_skip_instr), .i_enc_new(i_enc_new), .i_pc(i_pc),
    .i_dst_reg_wr(i_dst_reg_wr), .i_dst_reg(i_dst_reg), .i_dst_pred(i_dst_pred),
    .i_pred(i_pred), .i_rec_rdy(i_rec_rdy), .i_ovf_clr(i_ovf_clr),
    .o_rec_vld(vld0), .o_rec_pc(pc0), .o_rec_regs(regs0), .o_rec_pwr(pwr0),
    .o_rec_pval(pval0), .o_count(cnt0), .o_ovf(ovf0)
  );

  idli_retire_trace_m #(.WRAP(1)) u_dut1 (
    .gck(gck), .rst_n(rst_n), .i_ctr(i_ctr), .i_run_instr(i_run_instr),
    .i_skip_instr(i_skip_instr), .i_enc_new(i_enc_new), .i_pc(i_pc),
    .i_dst_reg_wr(i_dst_reg_wr), .i_dst_reg(i_dst_reg), .i_dst_pred(i_dst_pred),
    .i_pred(i_pred), .i_rec_rdy(i_rec_rdy), .i_ovf_clr(i_ovf_clr),
    .o_rec_vld(vld1), .o_rec_pc(pc1), .o_rec_regs(regs1), .o_rec_pwr(pwr1),
    .o_rec_pval(pval1), .o_count(cnt1), .o_ovf(ovf1)
  );

  always #5 gck = ~gck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue semantics of a bounded FIFO with either drop-new or drop-oldest policy
  task automatic model_step(input int sz, input bit push, input bit rdy, input bit wrap,
                            output bit pop_f, output bit push_b, output bit ovf_s);
    bit pop;
    pop    = (sz != 0) && rdy;
    pop_f  = pop;
    push_b = 1'b0;
    ovf_s  = 1'b0;
    if (push) begin
      if (pop || sz < DEPTH) begin
        push_b = 1'b1;
      end else begin
        ovf_s = 1'b1;
        if (wrap) begin
          pop_f  = 1'b1;
          push_b = 1'b1;
        end
      end
    end
  endtask

  // Monitor: compare presented head/occupancy against the scoreboard, then advance it
  always @(negedge gck) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mov0 = 1'b0;
      mov1 = 1'b0;
    end else begin
      chk("vld_w0", 64'(vld0), 64'(q0.size() != 0));
      chk("count_w0", 64'(cnt0), 64'(q0.size()));
      chk("ovf_w0", 64'(ovf0), 64'(mov0));
      if (q0.size() != 0) chk("rec_w0", 64'({pc0, regs0, pwr0, pval0}), 64'(q0[0]));
      model_step(q0.size(), exp_push, i_rec_rdy, 1'b0, pf, pb, os);
      if (pf) void'(q0.pop_front());
      if (pb) q0.push_back(exp_rec);
      if (os) mov0 = 1'b1;
      else if (i_ovf_clr) mov0 = 1'b0;

      chk("vld_w1", 64'(vld1), 64'(q1.size() != 0));
      chk("count_w1", 64'(cnt1), 64'(q1.size()));
      chk("ovf_w1", 64'(ovf1), 64'(mov1));
      if (q1.size() != 0) chk("rec_w1", 64'({pc1, regs1, pwr1, pval1}), 64'(q1[0]));
      model_step(q1.size(), exp_push, i_rec_rdy, 1'b1, pf, pb, os);
      if (pf) void'(q1.pop_front());
      if (pb) q1.push_back(exp_rec);
      if (os) mov1 = 1'b1;
      else if (i_ovf_clr) mov1 = 1'b0;
    end
  end

  // One instruction period (four slices); fields only matter in slice 0, other slices get junk
  task automatic run_period(input bit run, input bit enc, input logic [15:0] pc, input bit wr,
                            input logic [3:0] rg, input bit dpred, input bit skip, input bit newpred);
    for (int c = 0; c < 4; c++) begin
      @(posedge gck);
      #1;
      i_ctr        = 2'(c);
      i_run_instr  = run;
      i_skip_instr = skip;
      if (c == 0) begin
        exp_push      = pend_done;
        exp_rec       = pend_rec;
        exp_rec.pval  = i_pred;
        pend_done     = 1'b0;
        i_enc_new     = enc;
        i_pc          = pc;
        i_dst_reg_wr  = wr;
        i_dst_reg     = rg;
        i_dst_pred    = dpred;
        if (run) begin
          if (enc) model_pc = pc;
          pend_rec.pc   = model_pc;
          pend_rec.regs = (wr && rg != 0) ? (16'h1 << rg) : 16'h0;
          pend_rec.pwr  = dpred && !skip;
          pend_rec.pval = 1'b0;
        end
      end else begin
        exp_push     = 1'b0;
        i_enc_new    = 1'($urandom);
        i_pc         = 16'($urandom);
        i_dst_reg_wr = 1'($urandom);
        i_dst_reg    = 4'($urandom);
        i_dst_pred   = 1'($urandom);
        if (c == 1 && run && dpred && !skip) i_pred = newpred;
        if (c == 3) pend_done = run;
      end
      case (rdy_mode)
        0:       i_rec_rdy = 1'b0;
        1:       i_rec_rdy = 1'b1;
        2:       i_rec_rdy = 1'($urandom);
        3:       i_rec_rdy = (c == 0) && exp_push;
        default: i_rec_rdy = ($urandom_range(0, 9) == 0);
      endcase
      if (c == 0 && clr_once) begin
        i_ovf_clr = 1'b1;
        clr_once  = 1'b0;
      end else begin
        i_ovf_clr = clr_rand ? ($urandom_range(0, 19) == 0) : 1'b0;
      end
    end
  endtask

  task automatic instr(input logic [15:0] pc, input bit wr, input logic [3:0] rg,
                       input bit dpred, input bit skip, input bit newpred);
    run_period(1'b1, 1'b1, pc, wr, rg, dpred, skip, newpred);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_period(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_period();
    bit skip, wr;
    if ($urandom_range(0, 4) == 0) begin
      idle(1);
    end else begin
      skip = ($urandom_range(0, 3) == 0);
      wr   = skip ? 1'b0 : 1'($urandom);
      run_period(1'b1, $urandom_range(0, 7) != 0, 16'($urandom), wr, 4'($urandom),
                 1'($urandom), skip, 1'($urandom));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge gck);
    #3;
    chk("rst_vld", 64'({vld0, vld1}), 64'(0));
    chk("rst_count", 64'({cnt0, cnt1}), 64'(0));
    chk("rst_ovf", 64'({ovf0, ovf1}), 64'(0));
    chk("rst_rec", 64'({pc0, regs0, pwr0, pval0, pc1, regs1, pwr1, pval1}), 64'(0));
    rst_n = 1'b1;

    // Single retires and back-to-back retires with a ready consumer
    rdy_mode = 1;
    instr(16'h0042, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    idle(1);
    instr(16'h0050, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    idle(1);
    instr(16'h0051, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    idle(1);
    instr(16'h0060, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    instr(16'h0061, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Overflow: nine retires into eight entries with the consumer stalled
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) instr(16'(i), 1'b1, 4'((i % 15) + 1), 1'b0, 1'b0, 1'b0);
    idle(1);
    @(negedge gck);
    chk("ovfl_count_w0", 64'(cnt0), 64'(8));
    chk("ovfl_flag_w0", 64'(ovf0), 64'(1));
    chk("ovfl_head_w0", 64'(pc0), 64'(0));
    chk("ovfl_count_w1", 64'(cnt1), 64'(8));
    chk("ovfl_flag_w1", 64'(ovf1), 64'(1));
    chk("ovfl_head_w1", 64'(pc1), 64'(1));
    rdy_mode = 1;
    idle(3);
    clr_once = 1'b1;
    idle(1);
    @(negedge gck);
    chk("ovf_clr_w0", 64'(ovf0), 64'(0));
    chk("ovf_clr_w1", 64'(ovf1), 64'(0));

    // Full FIFO with a simultaneous push and pop
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) instr(16'h0100 + 16'(i), 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    rdy_mode = 3;
    idle(1);
    rdy_mode = 0;
    idle(1);
    @(negedge gck);
    chk("fullpp_count_w0", 64'(cnt0), 64'(8));
    chk("fullpp_count_w1", 64'(cnt1), 64'(8));
    chk("fullpp_ovf", 64'({ovf0, ovf1}), 64'(0));
    chk("fullpp_head", 64'({pc0, pc1}), 64'({16'h0101, 16'h0101}));
    rdy_mode = 1;
    idle(3);

    // Asynchronous reset while a push is pending
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) instr(16'h0200 + 16'(i), 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    @(posedge gck);
    #1;
    i_ctr        = 2'd0;
    i_run_instr  = 1'b0;
    i_enc_new    = 1'b0;
    i_dst_reg_wr = 1'b0;
    i_dst_pred   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'({vld0, vld1}), 64'(0));
    chk("midrst_count", 64'({cnt0, cnt1}), 64'(0));
    chk("midrst_ovf", 64'({ovf0, ovf1}), 64'(0));
    exp_push  = 1'b0;
    pend_done = 1'b0;
    model_pc  = '0;
    pend_rec  = '0;
    repeat (2) @(posedge gck);
    #3;
    rst_n = 1'b1;

    // Randomized traffic: moderate backpressure, then heavy backpressure to force overflow
    clr_rand = 1'b1;
    rdy_mode = 2;
    repeat (200) rand_period();
    rdy_mode = 4;
    repeat (120) rand_period();
    clr_rand = 1'b0;
    rdy_mode = 1;
    idle(4);
    @(negedge gck);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
